// File: rtl/sobel_pkg.sv
// Shared types for the Sobel line-buffer pipeline.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/counter.sv
// Non-saturating up-counter with synchronous load; load has priority over count.
module counter #(
  parameter int unsigned W_P = 8
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           en_i,
  input  logic           ld_i,
  input  logic [W_P-1:0] ld_val_i,
  output logic [W_P-1:0] cnt_o
);

  logic [W_P-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/linebuf_window_ctrl.sv
// Line-buffer sequencer: pixel handshake, shared shift enable, raster position
// tracking and a registered, backpressurable 3x3 window tag.
module linebuf_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH_P  = 640,
  parameter int unsigned HEIGHT_P = 480,
  parameter int unsigned COL_W_P  = $clog2(WIDTH_P),
  parameter int unsigned ROW_W_P  = $clog2(HEIGHT_P)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic               valid_i,
  input  logic               sof_i,
  output logic               ready_o,
  output logic               shift_en_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [COL_W_P-1:0] col_o,
  output logic [ROW_W_P-1:0] row_o,
  output logic               sof_o,
  output logic               eol_o,
  output logic               eof_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [COL_W_P-1:0] COL_LAST = COL_W_P'(WIDTH_P - 1);
  localparam logic [COL_W_P-1:0] COL_TWO  = COL_W_P'(2);
  localparam logic [ROW_W_P-1:0] ROW_LAST = ROW_W_P'(HEIGHT_P - 1);
  localparam logic [ROW_W_P-1:0] ROW_ONE  = ROW_W_P'(1);
  localparam logic [ROW_W_P-1:0] ROW_TWO  = ROW_W_P'(2);

  ctrl_state_e        state_q;
  logic [COL_W_P-1:0] col_q;
  logic [ROW_W_P-1:0] row_q;

  logic               valid_q, sof_q, eol_q, eof_q, done_q, err_q;
  logic [COL_W_P-1:0] tcol_q;
  logic [ROW_W_P-1:0] trow_q;

  logic               accept, resync, col_last, row_last, frame_last;
  logic [COL_W_P-1:0] eff_col, col_ld_val;
  logic [ROW_W_P-1:0] eff_row;

  assign ready_o    = (state_q != IDLE) & (~valid_q | ready_i);
  assign accept     = valid_i & ready_o;
  assign shift_en_o = accept;

  // A stray sof relabels the current pixel as (0,0); the tag and counters
  // then work from that effective position instead of the counted one.
  assign resync     = accept & sof_i & ((col_q != '0) | (row_q != '0));
  assign eff_col    = resync ? '0 : col_q;
  assign eff_row    = resync ? '0 : row_q;
  assign col_last   = (col_q == COL_LAST);
  assign row_last   = (row_q == ROW_LAST);
  assign frame_last = col_last & row_last & ~resync;
  assign col_ld_val = resync ? COL_W_P'(1) : '0;

  counter #(.W_P(COL_W_P)) u_col_cnt (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en_i     (accept),
    .ld_i     (accept & (resync | col_last)),
    .ld_val_i (col_ld_val),
    .cnt_o    (col_q)
  );

  counter #(.W_P(ROW_W_P)) u_row_cnt (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en_i     (accept & col_last),
    .ld_i     (accept & (resync | (col_last & row_last))),
    .ld_val_i ('0),
    .cnt_o    (row_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      tcol_q  <= '0;
      trow_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= accept & frame_last;
      if (resync) begin
        err_q <= 1'b1;
      end

      if (accept) begin
        valid_q <= (eff_row >= ROW_TWO) & (eff_col >= COL_TWO);
        tcol_q  <= eff_col - COL_W_P'(1);
        trow_q  <= eff_row - ROW_W_P'(1);
        sof_q   <= (eff_col == COL_TWO) & (eff_row == ROW_TWO);
        eol_q   <= (eff_col == COL_LAST);
        eof_q   <= (eff_col == COL_LAST) & (eff_row == ROW_LAST);
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (en_i) begin
            state_q <= FILL;
          end
        end
        FILL: begin
          if (accept && !resync && col_last && (row_q == ROW_ONE)) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (resync) begin
            state_q <= FILL;
          end else if (accept && frame_last) begin
            state_q <= en_i ? FILL : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign col_o   = tcol_q;
  assign row_o   = trow_q;
  assign sof_o   = sof_q;
  assign eol_o   = eol_q;
  assign eof_o   = eof_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Scoreboard bench for linebuf_window_ctrl on a 4x4 frame.
module tb_linebuf_window_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  logic       clk = 1'b0;
  logic       rstn, en, valid, sof, ready_i;
  logic       ready_o, shift, valid_o, sof_o, eol_o, eof_o, done_o, err_o;
  logic [1:0] col_o, row_o;

  typedef struct packed {
    logic [1:0] c;
    logic [1:0] r;
    logic       s;
    logic       l;
    logic       f;
  } tag_t;

  tag_t        exp_q[$];
  tag_t        mon_exp, mon_got;
  int unsigned vectors = 0, miscompares = 0;
  int unsigned shift_cnt = 0, done_cnt = 0, cyc = 0;
  int unsigned c0, c1;

  linebuf_window_ctrl #(.WIDTH_P(W), .HEIGHT_P(H)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .en_i       (en),
    .valid_i    (valid),
    .sof_i      (sof),
    .ready_o    (ready_o),
    .shift_en_o (shift),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .col_o      (col_o),
    .row_o      (row_o),
    .sof_o      (sof_o),
    .eol_o      (eol_o),
    .eof_o      (eof_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: a tag is consumed on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (shift) shift_cnt++;
    if (done_o) done_cnt++;
    if (valid_o && ready_i) begin
      vectors++;
      mon_got = '{col_o, row_o, sof_o, eol_o, eof_o};
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL tag_unexpected: got c=%0d r=%0d sof=%0b eol=%0b eof=%0b, required no tag",
                 col_o, row_o, sof_o, eol_o, eof_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          miscompares++;
          $display("FAIL tag: got c=%0d r=%0d sof=%0b eol=%0b eof=%0b, required c=%0d r=%0d sof=%0b eol=%0b eof=%0b",
                   mon_got.c, mon_got.r, mon_got.s, mon_got.l, mon_got.f,
                   mon_exp.c, mon_exp.r, mon_exp.s, mon_exp.l, mon_exp.f);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic s);
    bit acc = 1'b0;
    valid = 1'b1;
    sof   = s;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    sof   = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no accept in 100 cycles, required accept");
    end
  endtask

  task automatic push_frame_tags();
    for (int r = 1; r <= int'(H) - 2; r++)
      for (int c = 1; c <= int'(W) - 2; c++)
        exp_q.push_back('{2'(c), 2'(r), (c == 1 && r == 1), (c == int'(W) - 2),
                          (c == int'(W) - 2 && r == int'(H) - 2)});
  endtask

  task automatic send_frame();
    push_frame_tags();
    for (int i = 0; i < int'(W * H); i++) send(i == 0);
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_col", col_o, 0);
    chk("rst_row", row_o, 0);
    chk("rst_flags", {sof_o, eol_o, eof_o}, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_shift", shift, 0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; en = 1'b0; valid = 1'b0; sof = 1'b0; ready_i = 1'b1;
    do_reset();

    // IDLE ignores valid until enabled
    valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", ready_o, 0);
      chk("idle_shift", shift, 0);
    end
    @(posedge clk);
    #1;
    en = 1'b1;
    shift_cnt = 0;
    done_cnt  = 0;
    send_frame();
    chk("f1_done_pulse", done_o, 1);
    @(posedge clk);
    #1;
    chk("f1_done_low", done_o, 0);
    chk("f1_shift_cnt", shift_cnt, 16);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_tags_left", exp_q.size(), 0);

    // Downstream stall while tag (2,1) is presented
    shift_cnt = 0;
    push_frame_tags();
    for (int i = 0; i < 12; i++) send(i == 0);
    ready_i = 1'b0;
    valid   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", valid_o, 1);
      chk("stall_col", col_o, 2);
      chk("stall_row", row_o, 1);
      chk("stall_flags", {sof_o, eol_o, eof_o}, 3'b010);
      chk("stall_ready", ready_o, 0);
      chk("stall_shift", shift, 0);
      @(posedge clk);
      #1;
    end
    ready_i = 1'b1;
    valid   = 1'b0;
    for (int i = 12; i < 16; i++) send(1'b0);
    chk("f2_done_pulse", done_o, 1);
    @(posedge clk);
    #1;
    chk("f2_shift_cnt", shift_cnt, 16);
    chk("f2_tags_left", exp_q.size(), 0);

    // Back-to-back frames
    shift_cnt = 0;
    done_cnt  = 0;
    c0 = cyc;
    send_frame();
    send_frame();
    c1 = cyc;
    @(posedge clk);
    #1;
    chk("b2b_cycles", c1 - c0, 32);
    chk("b2b_shift_cnt", shift_cnt, 32);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_tags_left", exp_q.size(), 0);

    // Stray sof at (2,1) resynchronises the frame
    for (int i = 0; i < 6; i++) send(i == 0);
    chk("err_before", err_o, 0);
    push_frame_tags();
    send(1'b1);
    chk("err_set", err_o, 1);
    for (int i = 0; i < 15; i++) send(1'b0);
    chk("rs_done_pulse", done_o, 1);
    @(posedge clk);
    #1;
    chk("rs_tags_left", exp_q.size(), 0);
    chk("err_sticky", err_o, 1);

    // Reset mid-STREAM, then a clean frame
    exp_q.push_back('{2'd1, 2'd1, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 11; i++) send(i == 0);
    do_reset();
    chk("mr_tags_left", exp_q.size(), 0);
    send_frame();
    @(posedge clk);
    #1;
    chk("mr_frame_tags_left", exp_q.size(), 0);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
